// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
//   Shares one single-port framebuffer RAM between VGA scan-out reads and a
//   queued pixel writer. Scan-out reads addressed by nextX/nextY win whenever
//   the coordinate is visible and new. Queued writes use every other cycle:
//   blanking, and repeated coordinates when the pixel rate is below Clock.
//
// Ports
//   Clock, Reset          clock, asynchronous active-high reset
//   nextX, nextY          look-ahead scan coordinate from the VGA controller
//   pix_data, pix_valid   pixel read back from RAM, 2 cycles after nextX/nextY
//   wr_valid/wr_ready     writer handshake; wr_x, wr_y, wr_data carry the pixel
//   mem_addr/we/wdata     registered RAM command; mem_rdata is the read data
//   drop_count            saturating count of out-of-range writes discarded
//
// Build option
//   FB_CLEAR_EN  when defined, the RAM is cleared to zero after reset before
//                writes are accepted. Reads keep priority during the clear.
module framebuffer_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int WQ_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [10:0]       nextX,
  input  logic [9:0]        nextY,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_count
);

  localparam int              PTR_W  = $clog2(WQ_DEPTH);
  localparam logic [10:0]     H_LIM  = 11'(H_ACTIVE);
  localparam logic [9:0]      V_LIM  = 10'(V_ACTIVE);
  localparam logic [PTR_W:0]  Q_FULL = (PTR_W+1)'(WQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [10:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
  endfunction

  state_t              r_state, w_state_nxt;
  logic [10:0]         r_last_x;
  logic [9:0]          r_last_y;
  logic [ADDR_W-1:0]   r_q_addr [WQ_DEPTH];
  logic [DATA_W-1:0]   r_q_data [WQ_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [PTR_W:0]      r_count, w_count_nxt;
  logic                r_wr_ready;
  logic [ADDR_W-1:0]   r_mem_addr, w_addr_nxt;
  logic                r_mem_we, w_we_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_pix_data;
  logic                r_pix_valid;
  logic [15:0]         r_drop_count;
  logic                w_in_active, w_rd_slot, w_wr_in_range;
  logic                w_accept, w_push, w_drop, w_pop, w_q_empty;
  logic                w_clearing, w_clearing_nxt;
  logic [ADDR_W-1:0]   w_clr_addr;

  assign w_in_active   = (nextX < H_LIM) && (nextY < V_LIM);
  assign w_rd_slot     = w_in_active && !((nextX == r_last_x) && (nextY == r_last_y));
  assign w_wr_in_range = (wr_x < H_LIM) && (wr_y < V_LIM);
  assign w_accept      = wr_valid && r_wr_ready;
  assign w_push        = w_accept && w_wr_in_range;
  assign w_drop        = w_accept && !w_wr_in_range;
  assign w_q_empty     = (r_count == '0);

`ifdef FB_CLEAR_EN
  localparam logic              WR_READY_RST = 1'b0;
  localparam logic [ADDR_W-1:0] CLR_LAST     = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  logic              r_clearing;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              w_clr_step;

  assign w_clearing     = r_clearing;
  assign w_clr_addr     = r_clr_addr;
  assign w_clr_step     = r_clearing && (w_state_nxt == S_WR);
  assign w_clearing_nxt = r_clearing && !(w_clr_step && (r_clr_addr == CLR_LAST));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_clearing <= 1'b1;
      r_clr_addr <= '0;
    end else begin
      r_clearing <= w_clearing_nxt;
      if (w_clr_step) r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end
`else
  localparam logic WR_READY_RST = 1'b1;
  assign w_clearing     = 1'b0;
  assign w_clr_addr     = '0;
  assign w_clearing_nxt = 1'b0;
`endif

  // Slot FSM: state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Slot FSM: next state is the slot issued this cycle; reads always win
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_rd_slot)                     w_state_nxt = S_RD;
    else if (w_clearing || !w_q_empty) w_state_nxt = S_WR;
  end

  // Slot FSM: RAM command for the chosen slot; IDLE holds address and data
  always_comb begin
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_we_nxt    = 1'b0;
    w_pop       = 1'b0;
    case (w_state_nxt)
      S_RD: w_addr_nxt = f_addr(nextX, nextY);
      S_WR: begin
        w_we_nxt = 1'b1;
        if (w_clearing) begin
          w_addr_nxt  = w_clr_addr;
          w_wdata_nxt = '0;
        end else begin
          w_addr_nxt  = r_q_addr[r_rptr];
          w_wdata_nxt = r_q_data[r_rptr];
          w_pop       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
      default: ;
    endcase
  end

  // Registered RAM command, pixel output, queue control and counters
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_pix_data   <= '0;
      r_pix_valid  <= 1'b0;
      r_last_x     <= '1;
      r_last_y     <= '1;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_wr_ready   <= WR_READY_RST;
      r_drop_count <= '0;
    end else begin
      r_mem_addr  <= w_addr_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_wdata <= w_wdata_nxt;
      if (r_state == S_RD) begin
        r_pix_data  <= mem_rdata;
        r_pix_valid <= 1'b1;
      end else begin
        r_pix_data  <= '0;
        r_pix_valid <= 1'b0;
      end
      // Vertical blank forgets the last coordinate so the first pixel of the next frame is re-read
      if (nextY >= V_LIM) begin
        r_last_x <= '1;
        r_last_y <= '1;
      end else if (w_rd_slot) begin
        r_last_x <= nextX;
        r_last_y <= nextY;
      end
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_wr_ready <= !w_clearing_nxt && (w_count_nxt != Q_FULL);
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Queue payload carries no reset; occupancy is tracked by r_count
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= f_addr(wr_x, wr_y);
      r_q_data[r_wptr] <= wr_data;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign pix_data   = r_pix_data;
  assign pix_valid  = r_pix_valid;
  assign wr_ready   = r_wr_ready;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
module tb_framebuffer_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 19;
`ifdef FB_CLEAR_EN
  localparam logic EXP_RDY = 1'b0;
`else
  localparam logic EXP_RDY = 1'b1;
`endif

  logic              Clock = 1'b0;
  logic              Reset;
  logic [10:0]       nextX;
  logic [9:0]        nextY;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [10:0]       wr_x;
  logic [9:0]        wr_y;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       drop_count;

  int checks   = 0;
  int failures = 0;

  framebuffer_arbiter dut (
    .Clock(Clock), .Reset(Reset), .nextX(nextX), .nextY(nextY),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .drop_count(drop_count)
  );

  always #5 Clock = ~Clock;

  // RAM stand-in: read data is a fixed function of the presented address
  assign mem_rdata = mem_addr[7:0] ^ 8'h3C;

  task automatic idle_inputs();
    nextX = 11'd700; nextY = 10'd500;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge Clock);
    checks++; if (pix_data !== 8'h00) begin failures++; $display("FAIL rst_pix_data got=%0h exp=0", pix_data); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL rst_pix_valid got=%0b exp=0", pix_valid); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    checks++; if (mem_addr !== 19'd0) begin failures++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL rst_drop_count got=%0d exp=0", drop_count); end
    Reset = 1'b0;
    #1;
    checks++; if (wr_ready !== EXP_RDY) begin failures++; $display("FAIL rst_wr_ready_first got=%0b exp=%0b", wr_ready, EXP_RDY); end
    @(negedge Clock);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_idle_we got=%0b exp=0", mem_we); end
  endtask

  task automatic test_read();
    int pulses;
    nextX = 11'd5; nextY = 10'd2;
    @(negedge Clock);
    checks++; if (mem_addr !== 19'd1285) begin failures++; $display("FAIL rd_addr got=%0d exp=1285", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_we got=%0b exp=0", mem_we); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_early got=%0b exp=0", pix_valid); end
    @(negedge Clock);
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL rd_valid got=%0b exp=1", pix_valid); end
    checks++; if (pix_data !== 8'h39) begin failures++; $display("FAIL rd_data got=%0h exp=39", pix_data); end
    pulses = 0;
    repeat (5) begin
      @(negedge Clock);
      if (pix_valid === 1'b1 || pix_data !== 8'h00) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rd_single_pulse got=%0d extra exp=0", pulses); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_slow_pixel();
    nextX = 11'd100; nextY = 10'd10;
    wr_valid = 1'b1; wr_x = 11'd1; wr_y = 10'd1; wr_data = 8'h77;
    @(negedge Clock);
    wr_valid = 1'b0;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 19'd6500) begin failures++; $display("FAIL slow_rd got we=%0b addr=%0d exp we=0 addr=6500", mem_we, mem_addr); end
    @(negedge Clock);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'd641 || mem_wdata !== 8'h77) begin failures++; $display("FAIL slow_wr got we=%0b addr=%0d data=%0h exp we=1 addr=641 data=77", mem_we, mem_addr, mem_wdata); end
    checks++; if (pix_valid !== 1'b1 || pix_data !== 8'h58) begin failures++; $display("FAIL slow_pix got v=%0b d=%0h exp v=1 d=58", pix_valid, pix_data); end
    idle_inputs();
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_stall_queue();
    int we_seen;
    we_seen = 0;
    for (int i = 0; i < 640; i++) begin
      if (mem_we !== 1'b0) we_seen++;
      if (i == 4) begin
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL stall_full_ready got=%0b exp=0", wr_ready); end
      end
      nextX = 11'(i); nextY = 10'd0;
      wr_valid = (i < 4);
      wr_x = 11'(10 + i); wr_y = 10'd1; wr_data = 8'(8'h10 + i);
      @(negedge Clock);
    end
    wr_valid = 1'b0;
    if (mem_we !== 1'b0) we_seen++;
    checks++; if (we_seen !== 0) begin failures++; $display("FAIL stall_no_write got=%0d writes exp=0", we_seen); end
    nextX = 11'd640;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 19'(650 + k) || mem_wdata !== 8'(8'h10 + k)) begin
        failures++;
        $display("FAIL stall_drain%0d got we=%0b addr=%0d data=%0h exp we=1 addr=%0d data=%0h",
                 k, mem_we, mem_addr, mem_wdata, 650 + k, 8'h10 + k);
      end
    end
    @(negedge Clock);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL stall_after_drain_we got=%0b exp=0", mem_we); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_back got=%0b exp=1", wr_ready); end
    idle_inputs();
    @(negedge Clock);
  endtask

  task automatic test_corner_write();
    wr_valid = 1'b1; wr_x = 11'd639; wr_y = 10'd479; wr_data = 8'hA5;
    @(negedge Clock);
    wr_valid = 1'b0;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL corner_no_bypass got=%0b exp=0", mem_we); end
    @(negedge Clock);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'd307199 || mem_wdata !== 8'hA5) begin failures++; $display("FAIL corner_wr got we=%0b addr=%0d data=%0h exp we=1 addr=307199 data=a5", mem_we, mem_addr, mem_wdata); end
    @(negedge Clock);
  endtask

  task automatic test_drop();
    int we_seen;
    wr_valid = 1'b1; wr_x = 11'd640; wr_y = 10'd0; wr_data = 8'h11;
    #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL drop_ready got=%0b exp=1", wr_ready); end
    @(negedge Clock);
    wr_valid = 1'b0;
    checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL drop_count1 got=%0d exp=1", drop_count); end
    wr_valid = 1'b1; wr_x = 11'd3; wr_y = 10'd480;
    @(negedge Clock);
    wr_valid = 1'b0;
    checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL drop_count2 got=%0d exp=2", drop_count); end
    we_seen = 0;
    repeat (3) begin
      if (mem_we !== 1'b0) we_seen++;
      @(negedge Clock);
    end
    checks++; if (we_seen !== 0) begin failures++; $display("FAIL drop_no_write got=%0d writes exp=0", we_seen); end
  endtask

  task automatic test_reset_flush();
    int we_seen;
    for (int i = 0; i < 3; i++) begin
      nextX = 11'(i); nextY = 10'd3;
      wr_valid = 1'b1; wr_x = 11'(20 + i); wr_y = 10'd5; wr_data = 8'(8'h50 + i);
      @(negedge Clock);
    end
    idle_inputs();
    @(negedge Clock);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 19'd3220) begin failures++; $display("FAIL flush_pre got we=%0b addr=%0d exp we=1 addr=3220", mem_we, mem_addr); end
    Reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL flush_async_we got=%0b exp=0", mem_we); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL flush_drop_count got=%0d exp=0", drop_count); end
    @(negedge Clock);
    Reset = 1'b0;
    we_seen = 0;
    repeat (6) begin
      @(negedge Clock);
      if (mem_we !== 1'b0) we_seen++;
    end
    checks++; if (we_seen !== 0) begin failures++; $display("FAIL flush_stale got=%0d writes exp=0", we_seen); end
    checks++; if (wr_ready !== EXP_RDY) begin failures++; $display("FAIL flush_ready got=%0b exp=%0b", wr_ready, EXP_RDY); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_slow_pixel();
    test_stall_queue();
    test_corner_write();
    test_drop();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
